// File: rtl/accel_sequencer.sv
// Host-side sequencer for the convolution accelerator: fill staging, READ x2, wait, WRITE/capture, drain.
// Optional build macro ACCEL_SEQ_PERF_CNT_EN adds perf_jobs/perf_stall counters.
package accel_seq_pkg;
  typedef enum logic [1:0] {
    OP_NONE  = 2'd0,
    OP_READ  = 2'd1,
    OP_WRITE = 2'd2
  } accel_op_e;
endpackage

module accel_sequencer
  import accel_seq_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int DATA_OF_SET   = 128,
  parameter int IN_NUM_OF_SET = 16,
  parameter int OUT_SETS      = 8,
  parameter int WAIT_W        = 8
) (
  input  logic                                              clk,
  input  logic                                              rst,
  input  logic                                              in_valid,
  output logic                                              in_ready,
  input  logic [DATA_OF_SET*DATA_WIDTH-1:0]                 in_data,
  input  logic [WAIT_W-1:0]                                 wait_cycles,
  output accel_op_e                                         op,
  output logic [IN_NUM_OF_SET*DATA_OF_SET*DATA_WIDTH-1:0]   din,
  input  logic [OUT_SETS*DATA_OF_SET*DATA_WIDTH-1:0]        acc_dout,
  input  logic                                              acc_dout_valid,
  output logic                                              out_valid,
  input  logic                                              out_ready,
  output logic [DATA_OF_SET*DATA_WIDTH-1:0]                 out_data,
  output logic                                              out_last,
`ifdef ACCEL_SEQ_PERF_CNT_EN
  output logic [31:0]                                       perf_jobs,
  output logic [31:0]                                       perf_stall,
`endif
  output logic                                              busy
);

  localparam int SETW = DATA_OF_SET * DATA_WIDTH;
  localparam int SC_W = (IN_NUM_OF_SET > 1) ? $clog2(IN_NUM_OF_SET) : 1;
  localparam int OC_W = (OUT_SETS > 1) ? $clog2(OUT_SETS) : 1;

  typedef enum logic [2:0] {
    S_FILL,
    S_LOAD1,
    S_LOAD2,
    S_WAIT,
    S_FETCH,
    S_RETRY,
    S_DRAIN
  } state_e;

  state_e                               r_state;
  state_e                               w_next;
  logic [SC_W-1:0]                      r_set_cnt;
  logic [OC_W-1:0]                      r_out_cnt;
  logic [WAIT_W-1:0]                    r_wcnt;
  logic [IN_NUM_OF_SET-1:0][SETW-1:0]   r_din;
  logic [OUT_SETS-1:0][SETW-1:0]        r_cap;
  logic                                 w_last_set;
  logic                                 w_last_out;

  assign w_last_set = (r_set_cnt == SC_W'(IN_NUM_OF_SET - 1));
  assign w_last_out = (r_out_cnt == OC_W'(OUT_SETS - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_FILL;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FILL:  if (in_valid && w_last_set) w_next = S_LOAD1;
      S_LOAD1: w_next = S_LOAD2;
      S_LOAD2: w_next = S_WAIT;
      S_WAIT:  if (r_wcnt == '0) w_next = S_FETCH;
      S_FETCH: w_next = acc_dout_valid ? S_DRAIN : S_RETRY;
      S_RETRY: w_next = S_FETCH;
      S_DRAIN: if (out_ready && w_last_out) w_next = S_FILL;
      default: w_next = S_FILL;
    endcase
  end

  // in_ready is gated by rst so it reads 0 while reset is held, even though the state is already FILL.
  always_comb begin
    op        = OP_NONE;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    busy      = 1'b1;
    case (r_state)
      S_FILL: begin
        in_ready = rst;
        busy     = 1'b0;
      end
      S_LOAD1, S_LOAD2: op = OP_READ;
      S_FETCH:          op = OP_WRITE;
      S_DRAIN: begin
        out_valid = 1'b1;
        out_last  = w_last_out;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_set_cnt <= '0;
      r_out_cnt <= '0;
      r_wcnt    <= '0;
      r_din     <= '0;
      r_cap     <= '0;
    end else begin
      if (r_state == S_FILL && in_valid) begin
        r_din[r_set_cnt] <= in_data;
        r_set_cnt        <= w_last_set ? '0 : r_set_cnt + 1'b1;
      end
      if (r_state == S_LOAD2)
        r_wcnt <= wait_cycles;
      else if (r_state == S_WAIT && r_wcnt != '0)
        r_wcnt <= r_wcnt - 1'b1;
      if (r_state == S_FETCH && acc_dout_valid)
        r_cap <= acc_dout;
      if (r_state == S_DRAIN && out_ready)
        r_out_cnt <= w_last_out ? '0 : r_out_cnt + 1'b1;
    end
  end

  assign din      = r_din;
  assign out_data = r_cap[r_out_cnt];

`ifdef ACCEL_SEQ_PERF_CNT_EN
  logic [31:0] r_perf_jobs;
  logic [31:0] r_perf_stall;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_perf_jobs  <= '0;
      r_perf_stall <= '0;
    end else begin
      if (r_state == S_DRAIN && out_ready && w_last_out)
        r_perf_jobs <= r_perf_jobs + 1'b1;
      if ((r_state == S_DRAIN && !out_ready) || r_state == S_RETRY)
        r_perf_stall <= r_perf_stall + 1'b1;
    end
  end

  assign perf_jobs  = r_perf_jobs;
  assign perf_stall = r_perf_stall;
`else
  // Performance counters are compiled out in this build.
`endif

endmodule

// File: doc/accel_sequencer.md
Name: accel_sequencer

Overview:
Host-side initiator for the convolution accelerator's op/din/dout interface.
- Gathers input sets from an upstream valid/ready stream into the IN_NUM_OF_SET x DATA_OF_SET staging register.
- Issues the READ load sequence, waits a programmable compute interval, then issues WRITE and captures the 8-set result.
- Streams the captured result downstream one set per beat under valid/ready backpressure.

Parameters:
DATA_WIDTH, 32, bits per data word
DATA_OF_SET, 128, words per set (one stream beat)
IN_NUM_OF_SET, 16, sets per accelerator load
OUT_SETS, 8, result sets per WRITE capture
WAIT_W, 8, width of compute-wait counter

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset (all state cleared while low)
in_valid  in  1  input set valid
in_ready  out  1  input set accepted when in_valid & in_ready
in_data  in  DATA_OF_SET*DATA_WIDTH  one input set
wait_cycles  in  WAIT_W  cycles between end of load and WRITE; sampled at entry to WAIT
op  out  accel_op_e  command to accelerator (NONE/READ/WRITE)
din  out  IN_NUM_OF_SET*DATA_OF_SET*DATA_WIDTH  staged input, held stable throughout LOAD
acc_dout  in  OUT_SETS*DATA_OF_SET*DATA_WIDTH  accelerator result
acc_dout_valid  in  1  accelerator result valid
out_valid  out  1  result set valid
out_ready  in  1  downstream accept
out_data  out  DATA_OF_SET*DATA_WIDTH  one result set
out_last  out  1  high on final set (index OUT_SETS-1)
busy  out  1  high in any state except FILL

Behaviour:
- Reset values: op=NONE, in_ready=0, out_valid=0, out_last=0, busy=0, din=0, all counters 0, state=FILL.
- Reset mid-operation:
  - Abandon any sequence.
  - Discard staged and captured data.
  - Drive op=NONE on the first cycle after release.
- FILL:
  - in_ready=1, op=NONE.
  - Each handshake writes in_data to din[set_cnt], then set_cnt++.
  - When the handshake with set_cnt==IN_NUM_OF_SET-1 occurs: set_cnt->0, go to LOAD1. in_ready drops the next cycle.
- LOAD1: op=READ for 1 cycle, din stable -> LOAD2.
- LOAD2:
  - op=READ for a 2nd consecutive cycle.
  - The exact 2-cycle READ is mandatory: the accelerator writes on the READ rising edge and rearms only when READ is held 2 cycles.
  - Go to WAIT, loading wcnt=wait_cycles.
- WAIT:
  - op=NONE.
  - If wcnt==0 go to FETCH; else wcnt--.
  - wait_cycles=0 gives exactly 1 NONE cycle between READ and WRITE. That cycle is required: WRITE is recognised only on a non-WRITE to WRITE transition.
- FETCH:
  - op=WRITE for exactly 1 cycle.
  - If acc_dout_valid is high that cycle, latch acc_dout into cap and go to DRAIN.
  - Otherwise go to a RETRY cycle (op=NONE), then back to FETCH. Retries are unlimited.
- DRAIN:
  - op=NONE, out_valid=1, out_data=cap[out_cnt], out_last=(out_cnt==OUT_SETS-1).
  - On out_valid & out_ready, out_cnt++.
  - On the last handshake: out_cnt->0, go to FILL.
  - out_data/out_last hold while out_ready=0.
- A new fill cannot begin until the drain completes. in_ready=0 in every non-FILL state.
- Total load latency: last input handshake -> first READ cycle = 1 cycle.
- Min sequence latency: last input handshake -> out_valid = 1 + 2 + (wait_cycles+1) + 1 cycles.
- No arithmetic on data. Counters wrap-free: set_cnt is clog2(IN_NUM_OF_SET) bits, out_cnt is clog2(OUT_SETS) bits.

Optional Feature:
ACCEL_SEQ_PERF_CNT_EN
- Defined:
  - Adds outputs perf_jobs[31:0] (increments on each completed DRAIN) and perf_stall[31:0] (increments each DRAIN cycle with out_valid & !out_ready, plus each RETRY cycle).
  - Both are cleared by reset and wrap at 2^32.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Test Plan:
- Reset: hold rst=0 with random inputs -> op=NONE, in_ready=0, out_valid=0, busy=0; first cycle after release is FILL with in_ready=1.
- Basic job: 16 sets with in_data word0=set index, wait_cycles=3, acc_dout_valid high in FETCH with acc_dout[k] word0=100+k -> op sequence READ,READ,NONE x4,WRITE; 8 out beats with word0=100..107; out_last only on beat 7.
- Minimum wait: wait_cycles=0 -> exactly one NONE cycle between 2nd READ and WRITE; din unchanged across both READ cycles.
- Fetch retry: acc_dout_valid low for the first 2 FETCH cycles -> op pattern WRITE,NONE,WRITE,NONE,WRITE; capture on the 3rd WRITE.
- Backpressure: out_ready low 5 cycles on beat 3 -> out_data/out_last stable; beats emitted in order; in_ready=0 until after beat 7 handshake.
- Mid-job reset: assert rst=0 during WAIT -> op=NONE immediately; post-release a fresh 16-set fill is required before any READ.
